// File: rtl/patternbuf_loader_if.sv
// Host-side port bundle of the pattern buffer loader: transaction control,
// write byte stream in and readback byte stream out.
interface patternbuf_loader_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;

   modport master (
      output start, start_addr, wr_data, wr_valid,
      input  busy, done, wr_ready, rd_data, rd_valid
   );

   modport slave (
      input  start, start_addr, wr_data, wr_valid,
      output busy, done, wr_ready, rd_data, rd_valid
   );
endinterface

// File: rtl/patternbuf_loader.sv
// Scan-chain loader: serialises host bytes MSB first onto sin/sclk for the buffer
// selected by saddr, and returns the bits falling out of sout as readback bytes.
module patternbuf_loader #(
   parameter int BUFFER_SIZE  = 32,
   parameter int BUFFER_WIDTH = 8,
   parameter int SCLK_DIV     = 2
) (
   input  logic                clk,
   input  logic                reset,
   patternbuf_loader_if.slave  host,
   output logic                sclk,
   output logic                sin,
   output logic                ssel,
   output logic [2:0]          saddr,
   input  logic                sout
);

   localparam int BIT_W  = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
   localparam int BYTE_W = (BUFFER_SIZE > 1)  ? $clog2(BUFFER_SIZE)  : 1;
   localparam int DIV_W  = (SCLK_DIV > 1)     ? $clog2(SCLK_DIV)     : 1;
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BUFFER_WIDTH - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BUFFER_SIZE - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_WAIT, S_LOW, S_HIGH, S_HOLD, S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [2:0]              saddr_q, saddr_d;
   logic [BYTE_W-1:0]       byte_cnt_q, byte_cnt_d;
   logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
   logic [BUFFER_WIDTH-1:0] tx_q, tx_d;
   logic [BUFFER_WIDTH-1:0] rx_q, rx_d;
   logic [BUFFER_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                    rd_valid_q, rd_valid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    wr_ready_q, wr_ready_d;
   logic                    sclk_q, sclk_d;
   logic                    sin_q, sin_d;
   logic                    ssel_q, ssel_d;

   always_comb begin
      state_d    = state_q;
      saddr_d    = saddr_q;
      byte_cnt_d = byte_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      div_cnt_d  = div_cnt_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;

      case (state_q)
         S_IDLE: if (host.start) begin
            state_d    = S_SETUP;
            saddr_d    = host.start_addr;
            byte_cnt_d = '0;
         end
         S_SETUP: state_d = S_WAIT;
         S_WAIT: if (host.wr_valid && wr_ready_q) begin
            tx_d      = host.wr_data;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            state_d   = S_LOW;
         end
         S_LOW: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               state_d   = S_HIGH;
               // this edge raises sclk; sout still shows the bank's pre-shift bit
               rx_d      = {rx_q[BUFFER_WIDTH-2:0], sout};
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         S_HIGH: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               tx_d      = tx_q << 1;
               if (bit_cnt_q != BIT_LAST) begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  state_d   = S_LOW;
               end else if (byte_cnt_q != BYTE_LAST) begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  state_d    = S_WAIT;
               end else begin
                  state_d = S_HOLD;
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         S_HOLD:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs decode the next state so they register in step with it.
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      wr_ready_d = (state_d == S_WAIT);
      sclk_d     = (state_d == S_HIGH);
      ssel_d     = state_d inside {S_SETUP, S_WAIT, S_LOW, S_HIGH, S_HOLD};
      rd_valid_d = (state_d == S_HIGH) && (div_cnt_d == DIV_LAST) && (bit_cnt_d == BIT_LAST);
      if (rd_valid_d) rd_data_d = rx_d;

      // sin only moves on entry to / within LOW, so it is stable across the rising sclk
      case (state_d)
         S_LOW:   sin_d = tx_d[BUFFER_WIDTH-1];
         S_HIGH:  sin_d = sin_q;
         default: sin_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         saddr_q    <= '0;
         byte_cnt_q <= '0;
         bit_cnt_q  <= '0;
         div_cnt_q  <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_ready_q <= 1'b0;
         sclk_q     <= 1'b0;
         sin_q      <= 1'b0;
         ssel_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         saddr_q    <= saddr_d;
         byte_cnt_q <= byte_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         div_cnt_q  <= div_cnt_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_ready_q <= wr_ready_d;
         sclk_q     <= sclk_d;
         sin_q      <= sin_d;
         ssel_q     <= ssel_d;
      end
   end

   assign host.busy     = busy_q;
   assign host.done     = done_q;
   assign host.wr_ready = wr_ready_q;
   assign host.rd_data  = rd_data_q;
   assign host.rd_valid = rd_valid_q;
   assign sclk          = sclk_q;
   assign sin           = sin_q;
   assign ssel          = ssel_q;
   assign saddr         = saddr_q;

endmodule
